// File: rtl/batch_collector.sv
// Merges NUM_INPUTS AXI-Stream batch streams into one output without interleaving batches.
// Optional statistics counters are enabled by defining BATCH_COLLECTOR_STATS_EN.
module batch_collector #(
    parameter int NUM_INPUTS       = 4,
    parameter int MAX_DEPENDENCIES = 256,
    localparam int SRC_W           = $clog2(NUM_INPUTS)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_INPUTS-1:0]                  s_axis_tvalid,
    output logic [NUM_INPUTS-1:0]                  s_axis_tready,
    input  logic [NUM_INPUTS-1:0]                  s_axis_tlast,
    input  logic [NUM_INPUTS*64-1:0]               s_axis_tdata_owner_programID,
    input  logic [NUM_INPUTS*MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
    input  logic [NUM_INPUTS*MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic                                   m_axis_tlast,
    output logic [63:0]                            m_axis_tdata_owner_programID,
    output logic [MAX_DEPENDENCIES-1:0]            m_axis_tdata_read_dependencies,
    output logic [MAX_DEPENDENCIES-1:0]            m_axis_tdata_write_dependencies,
    output logic [SRC_W-1:0]                       m_axis_tsource
`ifdef BATCH_COLLECTOR_STATS_EN
    ,
    output logic [31:0]                            beats_forwarded,
    output logic [31:0]                            batches_forwarded,
    output logic [31:0]                            lock_stall_cycles
`endif
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                      state_q, state_d;
    logic [SRC_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]            lock_idx_q, lock_idx_d;

    logic                        m_valid_q, m_valid_d;
    logic                        m_last_q, m_last_d;
    logic [SRC_W-1:0]            m_src_q, m_src_d;
    logic [63:0]                 m_id_q, m_id_d;
    logic [MAX_DEPENDENCIES-1:0] m_rd_q, m_rd_d;
    logic [MAX_DEPENDENCIES-1:0] m_wr_q, m_wr_d;

    logic [SRC_W-1:0]            grant;
    logic [SRC_W-1:0]            search_idx;
    logic                        grant_valid;
    logic                        out_ready;
    logic                        accept;
    logic                        sel_last;
    logic [63:0]                 sel_id;
    logic [MAX_DEPENDENCIES-1:0] sel_rd;
    logic [MAX_DEPENDENCIES-1:0] sel_wr;

    // A locked batch owns the grant even while its source has no valid beat.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        search_idx  = '0;
        if (state_q == LOCKED) begin
            grant       = lock_idx_q;
            grant_valid = 1'b1;
        end else begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
                search_idx = rr_ptr_q + SRC_W'(k);
                if (!grant_valid && s_axis_tvalid[search_idx]) begin
                    grant       = search_idx;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    assign out_ready = !m_valid_q || m_axis_tready;
    assign accept    = grant_valid && s_axis_tvalid[grant] && out_ready;

    always_comb begin
        s_axis_tready = '0;
        sel_id        = '0;
        sel_rd        = '0;
        sel_wr        = '0;
        sel_last      = s_axis_tlast[grant];
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant == SRC_W'(i)) begin
                s_axis_tready[i] = rst_n && grant_valid && out_ready;
                sel_id           = s_axis_tdata_owner_programID[i*64 +: 64];
                sel_rd           = s_axis_tdata_read_dependencies[i*MAX_DEPENDENCIES +: MAX_DEPENDENCIES];
                sel_wr           = s_axis_tdata_write_dependencies[i*MAX_DEPENDENCIES +: MAX_DEPENDENCIES];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        m_valid_d  = m_valid_q && !m_axis_tready;
        m_last_d   = m_last_q;
        m_src_d    = m_src_q;
        m_id_d     = m_id_q;
        m_rd_d     = m_rd_q;
        m_wr_d     = m_wr_q;
        if (accept) begin
            m_valid_d = 1'b1;
            m_last_d  = sel_last;
            m_src_d   = grant;
            m_id_d    = sel_id;
            m_rd_d    = sel_rd;
            m_wr_d    = sel_wr;
            if (sel_last) begin
                state_d  = IDLE;
                rr_ptr_d = grant + SRC_W'(1);
            end else begin
                state_d    = LOCKED;
                lock_idx_d = grant;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_src_q    <= '0;
            m_id_q     <= '0;
            m_rd_q     <= '0;
            m_wr_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            m_src_q    <= m_src_d;
            m_id_q     <= m_id_d;
            m_rd_q     <= m_rd_d;
            m_wr_q     <= m_wr_d;
        end
    end

    assign m_axis_tvalid                   = m_valid_q;
    assign m_axis_tlast                    = m_last_q;
    assign m_axis_tsource                  = m_src_q;
    assign m_axis_tdata_owner_programID    = m_id_q;
    assign m_axis_tdata_read_dependencies  = m_rd_q;
    assign m_axis_tdata_write_dependencies = m_wr_q;

`ifdef BATCH_COLLECTOR_STATS_EN
    logic [31:0] beats_q, beats_d;
    logic [31:0] batches_q, batches_d;
    logic [31:0] stall_q, stall_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        beats_d   = beats_q;
        batches_d = batches_q;
        stall_d   = stall_q;
        if (m_valid_q && m_axis_tready) begin
            beats_d = beats_q + 32'd1;
            if (m_last_q) begin
                batches_d = batches_q + 32'd1;
            end
        end
        if (state_q == LOCKED && !s_axis_tvalid[lock_idx_q]) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_q   <= '0;
            batches_q <= '0;
            stall_q   <= '0;
        end else begin
            beats_q   <= beats_d;
            batches_q <= batches_d;
            stall_q   <= stall_d;
        end
    end

    assign beats_forwarded   = beats_q;
    assign batches_forwarded = batches_q;
    assign lock_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_batch_collector.sv
// Directed self-checking bench for batch_collector (default 4 inputs, 256-bit dependencies).
// Define BATCH_COLLECTOR_STATS_EN to also exercise the statistics counters.
module tb_batch_collector;

    localparam int N  = 4;
    localparam int MD = 256;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tready;
    logic [N-1:0]      s_tlast;
    logic [N*64-1:0]   s_id;
    logic [N*MD-1:0]   s_rd;
    logic [N*MD-1:0]   s_wr;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic [63:0]       m_id;
    logic [MD-1:0]     m_rd;
    logic [MD-1:0]     m_wr;
    logic [1:0]        m_src;
`ifdef BATCH_COLLECTOR_STATS_EN
    logic [31:0]       beats_fwd;
    logic [31:0]       batches_fwd;
    logic [31:0]       stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    batch_collector #(.NUM_INPUTS(N), .MAX_DEPENDENCIES(MD)) dut (
        .clk                             (clk),
        .rst_n                           (rst_n),
        .s_axis_tvalid                   (s_tvalid),
        .s_axis_tready                   (s_tready),
        .s_axis_tlast                    (s_tlast),
        .s_axis_tdata_owner_programID    (s_id),
        .s_axis_tdata_read_dependencies  (s_rd),
        .s_axis_tdata_write_dependencies (s_wr),
        .m_axis_tvalid                   (m_tvalid),
        .m_axis_tready                   (m_tready),
        .m_axis_tlast                    (m_tlast),
        .m_axis_tdata_owner_programID    (m_id),
        .m_axis_tdata_read_dependencies  (m_rd),
        .m_axis_tdata_write_dependencies (m_wr),
        .m_axis_tsource                  (m_src)
`ifdef BATCH_COLLECTOR_STATS_EN
        ,
        .beats_forwarded                 (beats_fwd),
        .batches_forwarded               (batches_fwd),
        .lock_stall_cycles               (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Dependencies are derived from the ID so one expected ID pins the whole beat.
    task automatic set_beat(input int i, input logic v, input logic l, input logic [63:0] id);
        s_tvalid[i]          = v;
        s_tlast[i]           = l;
        s_id[i*64 +: 64]     = id;
        s_rd[i*MD +: MD]     = ~MD'(id);
        s_wr[i*MD +: MD]     = MD'(id) << 100;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        m_tready = 1'b1;
        s_tvalid = '1;
        s_tlast  = '1;
        s_id     = '1;
        s_rd     = '1;
        s_wr     = '1;
        tick();
        tick();
        checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_src !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got valid=%b last=%b src=%0d, want 0 0 0", m_tvalid, m_tlast, m_src);
        end
        checks++;
        if (m_id !== 64'd0 || m_rd !== '0 || m_wr !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got id=%h, want 0 with zero dependencies", m_id);
        end
        checks++;
        if (s_tready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b, want 0000", s_tready);
        end
`ifdef BATCH_COLLECTOR_STATS_EN
        checks++;
        if (beats_fwd !== 32'd0 || batches_fwd !== 32'd0 || stall_cnt !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_stats: got %0d %0d %0d, want 0 0 0", beats_fwd, batches_fwd, stall_cnt);
        end
`endif
        for (int i = 0; i < N; i++) set_beat(i, 1'b0, 1'b0, 64'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < N; i++) set_beat(i, 1'b1, 1'b1, 64'h10 + i);
        #1;
        checks++;
        if (s_tready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL rr_first_ready: got %b, want 0001", s_tready);
        end
        for (int k = 0; k < N; k++) begin
            tick();
            set_beat(k, 1'b0, 1'b0, 64'd0);
            checks++;
            if (m_tvalid !== 1'b1 || m_src !== 2'(k) || m_id !== 64'h10 + k || m_tlast !== 1'b1 ||
                m_rd !== ~MD'(64'h10 + k) || m_wr !== (MD'(64'h10 + k) << 100)) begin
                errors++;
                $display("[TB] FAIL rr_beat%0d: got valid=%b src=%0d id=%h last=%b, want 1 %0d %h 1",
                         k, m_tvalid, m_src, m_id, m_tlast, k, 64'h10 + k);
            end
        end
        tick();
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rr_drain: got valid=%b, want 0", m_tvalid);
        end
    endtask

    task automatic test_locked_batch();
        set_beat(2, 1'b1, 1'b0, 64'hA0);
        tick();
        checks++;
        if (m_tvalid !== 1'b1 || m_src !== 2'd2 || m_id !== 64'hA0 || m_tlast !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lock_a0: got src=%0d id=%h last=%b, want 2 a0 0", m_src, m_id, m_tlast);
        end
        set_beat(0, 1'b1, 1'b1, 64'h50);
        set_beat(2, 1'b1, 1'b0, 64'hA1);
        #1;
        checks++;
        if (s_tready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL lock_ready_a1: got %b, want 0100", s_tready);
        end
        tick();
        checks++;
        if (m_src !== 2'd2 || m_id !== 64'hA1 || m_tlast !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lock_a1: got src=%0d id=%h last=%b, want 2 a1 0", m_src, m_id, m_tlast);
        end
        set_beat(2, 1'b1, 1'b1, 64'hA2);
        #1;
        checks++;
        if (s_tready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL lock_ready_a2: got %b, want 0100", s_tready);
        end
        tick();
        checks++;
        if (m_src !== 2'd2 || m_id !== 64'hA2 || m_tlast !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lock_a2: got src=%0d id=%h last=%b, want 2 a2 1", m_src, m_id, m_tlast);
        end
        set_beat(2, 1'b0, 1'b0, 64'd0);
        tick();
        set_beat(0, 1'b0, 1'b0, 64'd0);
        checks++;
        if (m_tvalid !== 1'b1 || m_src !== 2'd0 || m_id !== 64'h50 || m_tlast !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lock_then_inst0: got valid=%b src=%0d id=%h, want 1 0 50", m_tvalid, m_src, m_id);
        end
        tick();
    endtask

    // Instance 1 holds the lock while idle; instance 3 must wait for the batch end.
    task automatic test_lock_stall();
        set_beat(1, 1'b1, 1'b0, 64'hB0);
        tick();
        set_beat(1, 1'b0, 1'b0, 64'd0);
        set_beat(3, 1'b1, 1'b1, 64'h33);
        for (int s = 0; s < 5; s++) begin
            #1;
            checks++;
            if (s_tready !== 4'b0010) begin
                errors++;
                $display("[TB] FAIL stall_ready%0d: got %b, want 0010", s, s_tready);
            end
            tick();
        end
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_no_grant: got valid=%b src=%0d, want valid 0", m_tvalid, m_src);
        end
        set_beat(1, 1'b1, 1'b1, 64'hB1);
        tick();
        set_beat(1, 1'b0, 1'b0, 64'd0);
        checks++;
        if (m_tvalid !== 1'b1 || m_src !== 2'd1 || m_id !== 64'hB1 || m_tlast !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_b1: got src=%0d id=%h last=%b, want 1 b1 1", m_src, m_id, m_tlast);
        end
        tick();
        set_beat(3, 1'b0, 1'b0, 64'd0);
        checks++;
        if (m_tvalid !== 1'b1 || m_src !== 2'd3 || m_id !== 64'h33) begin
            errors++;
            $display("[TB] FAIL stall_inst3: got src=%0d id=%h, want 3 33", m_src, m_id);
        end
        tick();
`ifdef BATCH_COLLECTOR_STATS_EN
        checks++;
        if (stall_cnt !== 32'd5 || beats_fwd !== 32'd11 || batches_fwd !== 32'd8) begin
            errors++;
            $display("[TB] FAIL stats: got stall=%0d beats=%0d batches=%0d, want 5 11 8",
                     stall_cnt, beats_fwd, batches_fwd);
        end
`endif
    endtask

    task automatic test_backpressure();
        m_tready = 1'b0;
        set_beat(0, 1'b1, 1'b0, 64'hC0);
        tick();
        set_beat(0, 1'b1, 1'b1, 64'hC1);
        for (int s = 0; s < 4; s++) begin
            #1;
            checks++;
            if (s_tready !== 4'b0000 || m_tvalid !== 1'b1 || m_id !== 64'hC0 || m_src !== 2'd0 ||
                m_tlast !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got ready=%b valid=%b id=%h, want 0000 1 c0",
                         s, s_tready, m_tvalid, m_id);
            end
            tick();
        end
        m_tready = 1'b1;
        #1;
        checks++;
        if (s_tready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL bp_release_ready: got %b, want 0001", s_tready);
        end
        tick();
        set_beat(0, 1'b0, 1'b0, 64'd0);
        checks++;
        if (m_tvalid !== 1'b1 || m_id !== 64'hC1 || m_tlast !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_c1: got valid=%b id=%h last=%b, want 1 c1 1", m_tvalid, m_id, m_tlast);
        end
        tick();
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_drain: got valid=%b, want 0", m_tvalid);
        end
    endtask

    task automatic test_reset_midbatch();
        set_beat(1, 1'b1, 1'b0, 64'hD0);
        tick();
        set_beat(1, 1'b1, 1'b0, 64'hD1);
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_id !== 64'd0 || s_tready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midrst_clear: got valid=%b id=%h ready=%b, want 0 0 0000", m_tvalid, m_id, s_tready);
        end
        set_beat(0, 1'b1, 1'b1, 64'hE0);
        set_beat(1, 1'b1, 1'b0, 64'hD0);
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_tready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL midrst_grant: got ready=%b, want 0001", s_tready);
        end
        tick();
        for (int i = 0; i < N; i++) set_beat(i, 1'b0, 1'b0, 64'd0);
        checks++;
        if (m_tvalid !== 1'b1 || m_src !== 2'd0 || m_id !== 64'hE0) begin
            errors++;
            $display("[TB] FAIL midrst_beat: got valid=%b src=%0d id=%h, want 1 0 e0", m_tvalid, m_src, m_id);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_locked_batch();
        test_lock_stall();
        test_backpressure();
        test_reset_midbatch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/batch_collector.md
BATCH_COLLECTOR -- requirements
Module: batch_collector

Interface
- REQ-001: The block SHALL have parameter NUM_INPUTS, default 4: number of upstream conflict-detection instance streams merged; power of two, 2 to 16.
- REQ-002: The block SHALL have parameter MAX_DEPENDENCIES, default 256: width of each dependency bitmap.
- REQ-003: The block SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
- REQ-004: The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-005: The block SHALL have port s_axis_tvalid, input, NUM_INPUTS bits: per-instance beat valid.
- REQ-006: The block SHALL have port s_axis_tready, output, NUM_INPUTS bits: per-instance beat accepted.
- REQ-007: The block SHALL have port s_axis_tlast, input, NUM_INPUTS bits: the beat closes its instance's batch.
- REQ-008: The block SHALL have port s_axis_tdata_owner_programID, input, NUM_INPUTS*64 bits: flattened; instance i occupies bits [i*64 +: 64].
- REQ-009: The block SHALL have ports s_axis_tdata_read_dependencies and s_axis_tdata_write_dependencies, input, NUM_INPUTS*MAX_DEPENDENCIES bits each: flattened like REQ-008.
- REQ-010: The block SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1): the merged output handshake and end of batch.
- REQ-011: The block SHALL have ports m_axis_tdata_owner_programID (output, 64), m_axis_tdata_read_dependencies (output, MAX_DEPENDENCIES) and m_axis_tdata_write_dependencies (output, MAX_DEPENDENCIES).
- REQ-012: The block SHALL have port m_axis_tsource, output, $clog2(NUM_INPUTS) bits: index of the instance that produced the beat.

Function
- REQ-013: The arbiter SHALL have two states, IDLE and LOCKED, plus a rotating pointer rr_ptr and a locked index lock_idx.
- REQ-014: In IDLE, the grant SHALL go to the first asserted s_axis_tvalid found by searching upward from rr_ptr, modulo NUM_INPUTS; with no tvalid asserted there is no grant.
- REQ-015: In LOCKED, the grant SHALL be fixed to lock_idx whatever the other tvalid bits are.
- REQ-016: s_axis_tready[i] SHALL equal (grant == i) AND (output register empty OR m_axis_tready); all other ready bits SHALL be 0; ready SHALL be combinational.
- REQ-017: An accepted beat with tlast=0 SHALL move to (IDLE) or stay in (LOCKED) the LOCKED state with lock_idx = grant.
- REQ-018: An accepted beat with tlast=1 SHALL move to IDLE and set rr_ptr = (grant+1) mod NUM_INPUTS; a single-beat batch in IDLE SHALL also do this.
- REQ-019: Beats of one batch SHALL never be interleaved with beats from another instance on the output.
- REQ-020: The output SHALL be a single register stage: an accepted beat appears on the m_axis outputs the next cycle, with its data, tlast and tsource.
- REQ-021: Throughput SHALL be one beat per cycle while m_axis_tready=1.
- REQ-022: The m_axis outputs SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- REQ-023: m_axis_tvalid SHALL clear the cycle after a consumed beat when no new beat is accepted in the same cycle.
- REQ-024: A simultaneous consume and accept SHALL keep m_axis_tvalid=1 and load the new beat.
- REQ-025: tvalid dropping mid-batch on the locked source SHALL keep the LOCKED state indefinitely, with no grant given to other instances.

Reset
- REQ-026: While rst_n=0, state SHALL be IDLE, rr_ptr=0 and lock_idx=0.
- REQ-027: While rst_n=0, m_axis_tvalid, m_axis_tlast, m_axis_tsource and all m_axis data SHALL be 0, and s_axis_tready SHALL be all 0.
- REQ-028: Reset asserted mid-batch SHALL discard the partial batch, including any beat held in the output register.

Configuration
- REQ-029: With macro BATCH_COLLECTOR_STATS_EN defined, the block SHALL add 32-bit outputs beats_forwarded, batches_forwarded and lock_stall_cycles, each reset to 0 and wrapping on overflow.
- REQ-030: With BATCH_COLLECTOR_STATS_EN defined, beats_forwarded SHALL count output handshakes, batches_forwarded SHALL count handshakes with tlast=1, and lock_stall_cycles SHALL count cycles in LOCKED with the locked source's tvalid=0.
- REQ-031: Without BATCH_COLLECTOR_STATS_EN, these ports and their logic SHALL be absent, and arbitration and datapath SHALL be unchanged.

Verification
- REQ-032: After reset, all four instances present a 1-beat batch each with tlast=1 and m_axis_tready=1 -> m_axis_tsource sequence 0,1,2,3, beats on 4 consecutive cycles, first beat one cycle after acceptance.
- REQ-033: Instance 2 sends a 3-beat batch with IDs 0xA0..0xA2 while instance 0 holds tvalid -> output 0xA0,0xA1,0xA2 with tlast only on 0xA2, then instance 0; s_axis_tready[0]=0 throughout the batch.
- REQ-034: Instance 1 sends beat 1 of 2 then drops tvalid for 5 cycles while instance 3 is valid -> instance 3 is not granted; with STATS, lock_stall_cycles=5.
- REQ-035: m_axis_tready=0 for 4 cycles with output full -> outputs stable and all s_axis_tready=0; on release, no beat is lost or duplicated.
- REQ-036: rst_n asserted after beat 2 of a 4-beat batch -> m_axis_tvalid=0 immediately, state IDLE, rr_ptr=0; next grant follows REQ-014 from 0.
